// File: rtl/keyed_dupe_burst_fsm.sv
// Key-locked burst controller. A wrong key at DONE parks the machine in one of
// N_DUPE look-alike idle states whose index silently lengthens the next burst.
module keyed_dupe_burst_fsm #(
  parameter int               KEY_W       = 8,
  parameter logic [KEY_W-1:0] CORRECT_KEY = 8'hA5,
  parameter int               N_DUPE      = 4,
  parameter int               LEN_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             en,
  input  logic             abort,
  input  logic [KEY_W-1:0] keyinput,
  output logic             busy,
  output logic             tick,
  output logic             done,
  output logic [LEN_W-1:0] cnt
);

  localparam int IDX_W = $clog2(N_DUPE);

  // A duplicate idle state is S_DI plus its index; idx_reg is zero in every other state.
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_DI} kind_t;

  kind_t            kind_reg, kind_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [LEN_W-1:0] cnt_reg, cnt_next;
  logic [LEN_W-1:0] eff_len;
  logic             busy_reg, done_reg;

  always_comb begin
    kind_next = kind_reg;
    idx_next  = '0;
    cnt_next  = cnt_reg;
    eff_len   = len + LEN_W'(idx_reg) + LEN_W'(1);

    if (kind_reg != S_DI && idx_reg != '0) begin
      kind_next = S_IDLE;
      cnt_next  = '0;
    end else begin
      case (kind_reg)
        S_IDLE: begin
          if (start) begin
            if (len != '0) begin
              kind_next = S_RUN;
              cnt_next  = len;
            end else begin
              kind_next = S_DONE;
              cnt_next  = '0;
            end
          end
        end
        S_DI: begin
          if (start) begin
            if (eff_len != '0) begin
              kind_next = S_RUN;
              cnt_next  = eff_len;
            end else begin
              kind_next = S_DONE;
              cnt_next  = '0;
            end
          end else begin
            // Walking through the duplicates makes the corruption depend on idle time.
            kind_next = S_DI;
            idx_next  = idx_reg + IDX_W'(1);
          end
        end
        S_RUN: begin
          if (abort) begin
            kind_next = S_DONE;
            cnt_next  = '0;
          end else if (en) begin
            if (cnt_reg <= LEN_W'(1)) begin
              kind_next = S_DONE;
              cnt_next  = '0;
            end else begin
              cnt_next = cnt_reg - LEN_W'(1);
            end
          end
        end
        S_DONE: begin
          if (keyinput == CORRECT_KEY) begin
            kind_next = S_IDLE;
          end else begin
            kind_next = S_DI;
            idx_next  = keyinput[IDX_W-1:0];
          end
        end
        default: begin
          kind_next = S_IDLE;
          cnt_next  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kind_reg <= S_IDLE;
      idx_reg  <= '0;
      cnt_reg  <= '0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      kind_reg <= kind_next;
      idx_reg  <= idx_next;
      cnt_reg  <= cnt_next;
      busy_reg <= (kind_next == S_RUN);
      done_reg <= (kind_next == S_DONE);
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign cnt  = cnt_reg;
  assign tick = busy_reg & en & ~abort;

endmodule

// File: tb/tb_keyed_dupe_burst_fsm.sv
// Bench for keyed_dupe_burst_fsm: directed scenarios with fixed expectations,
// then random traffic against a burst-level reference model.
module tb_keyed_dupe_burst_fsm;

  localparam int         KEY_W  = 8;
  localparam int         N_DUPE = 4;
  localparam int         LEN_W  = 8;
  localparam logic [7:0] GOOD   = 8'hA5;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, en, abort;
  logic [7:0] len, keyinput;
  logic       busy, tick, done;
  logic [7:0] cnt;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  keyed_dupe_burst_fsm #(
    .KEY_W(KEY_W), .CORRECT_KEY(GOOD), .N_DUPE(N_DUPE), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .en(en), .abort(abort),
    .keyinput(keyinput), .busy(busy), .tick(tick), .done(done), .cnt(cnt)
  );

  // Reference model: mode 0 idle, 1 running, 2 done. A locked idle remembers
  // a walk position that adds (walk+1) to the next requested length.
  int m_mode   = 0;
  bit m_locked = 1'b0;
  int m_walk   = 0;
  int m_cnt    = 0;

  function automatic int eff_of(int l, bit lk, int w);
    return lk ? (l + w + 1) % 256 : l;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode <= 0; m_locked <= 1'b0; m_walk <= 0; m_cnt <= 0;
    end else begin
      case (m_mode)
        0: begin
          if (start) begin
            if (eff_of(int'(len), m_locked, m_walk) != 0) begin
              m_mode <= 1; m_cnt <= eff_of(int'(len), m_locked, m_walk);
            end else begin
              m_mode <= 2; m_cnt <= 0;
            end
            m_locked <= 1'b0;
          end else if (m_locked) begin
            m_walk <= (m_walk + 1) % N_DUPE;
          end
        end
        1: begin
          if (abort) begin
            m_mode <= 2; m_cnt <= 0;
          end else if (en) begin
            if (m_cnt == 1) begin m_mode <= 2; m_cnt <= 0; end
            else m_cnt <= m_cnt - 1;
          end
        end
        default: begin
          m_mode <= 0;
          if (keyinput == GOOD) m_locked <= 1'b0;
          else begin m_locked <= 1'b1; m_walk <= int'(keyinput) % N_DUPE; end
        end
      endcase
    end
  end

  task automatic set_in(input logic s, input logic [7:0] l, input logic e, input logic a);
    start = s; len = l; en = e; abort = a;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; set_in(0, 8'h00, 1, 0);
    next_cycle();
    rst = 1'b0;
    next_cycle();
  endtask

  // Issues one start with en held high; reports ticks seen and cycles to done (-1 on timeout).
  task automatic run_burst(input logic [7:0] l, input logic [7:0] k, output int ticks, output int lat);
    keyinput = k;
    set_in(1, l, 1, 0);
    next_cycle();
    set_in(0, 8'h00, 1, 0);
    ticks = 0; lat = -1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (tick) ticks++;
      if (done) begin lat = i; break; end
      next_cycle();
    end
    next_cycle();
  endtask

  task automatic test_reset();
    set_in(1, 8'd5, 1, 0); keyinput = GOOD;
    rst = 1'b0; #1; rst = 1'b1; #1;
    compared++;
    if ({busy, tick, done, cnt} !== 11'b0) begin
      mismatched++; $display("FAIL reset_async: got %h expected 000", {busy, tick, done, cnt});
    end
    repeat (2) next_cycle();
    compared++;
    if ({busy, tick, done, cnt} !== 11'b0) begin
      mismatched++; $display("FAIL reset_held: got %h expected 000", {busy, tick, done, cnt});
    end
    @(negedge clk); rst = 1'b0; set_in(0, 8'h00, 1, 0);
    next_cycle();
    compared++;
    if ({busy, tick, done, cnt} !== 11'b0) begin
      mismatched++; $display("FAIL reset_idle: got %h expected 000", {busy, tick, done, cnt});
    end
  endtask

  task automatic test_correct_key();
    int ticks, lat;
    keyinput = GOOD;
    set_in(1, 8'd3, 1, 0);
    next_cycle();
    set_in(0, 8'h00, 1, 0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      compared++;
      if ({busy, tick, done, cnt} !== {c <= 3, c <= 3, c == 4, (c <= 3) ? 8'(4 - c) : 8'd0}) begin
        mismatched++;
        $display("FAIL correct_key_cycle%0d: got %h expected %h", c, {busy, tick, done, cnt},
                 {c <= 3, c <= 3, c == 4, (c <= 3) ? 8'(4 - c) : 8'd0});
      end
      next_cycle();
    end
    run_burst(8'd3, GOOD, ticks, lat);
    compared++;
    if (ticks !== 3 || lat !== 4) begin
      mismatched++; $display("FAIL correct_key_repeat: got ticks=%0d lat=%0d expected ticks=3 lat=4", ticks, lat);
    end
  endtask

  task automatic test_wrong_key();
    int ticks, lat;
    do_reset();
    run_burst(8'd3, 8'h03, ticks, lat);
    compared++;
    if (ticks !== 3 || lat !== 4) begin
      mismatched++; $display("FAIL wrong_key_first: got ticks=%0d lat=%0d expected ticks=3 lat=4", ticks, lat);
    end
    run_burst(8'd3, 8'h03, ticks, lat);
    compared++;
    if (ticks !== 7 || lat !== 8) begin
      mismatched++; $display("FAIL wrong_key_di3: got ticks=%0d lat=%0d expected ticks=7 lat=8", ticks, lat);
    end
    set_in(0, 8'h00, 1, 0);
    next_cycle();
    run_burst(8'd3, 8'h03, ticks, lat);
    compared++;
    if (ticks !== 4 || lat !== 5) begin
      mismatched++; $display("FAIL wrong_key_di0: got ticks=%0d lat=%0d expected ticks=4 lat=5", ticks, lat);
    end
  endtask

  task automatic test_en_gating();
    logic en_pat   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic exp_tick [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic exp_done [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] exp_cnt [4] = '{8'd2, 8'd1, 8'd1, 8'd0};
    do_reset();
    keyinput = GOOD;
    set_in(1, 8'd2, 1, 0);
    next_cycle();
    for (int c = 0; c < 4; c++) begin
      set_in(0, 8'h00, en_pat[c], 0);
      @(negedge clk);
      compared++;
      if ({tick, done, cnt} !== {exp_tick[c], exp_done[c], exp_cnt[c]}) begin
        mismatched++;
        $display("FAIL en_gating_cycle%0d: got %h expected %h", c, {tick, done, cnt},
                 {exp_tick[c], exp_done[c], exp_cnt[c]});
      end
      next_cycle();
    end
  endtask

  task automatic test_abort();
    keyinput = GOOD;
    set_in(1, 8'd5, 1, 0);
    next_cycle();
    set_in(0, 8'h00, 1, 0);
    @(negedge clk);
    compared++;
    if ({busy, tick, done, cnt} !== {1'b1, 1'b1, 1'b0, 8'd5}) begin
      mismatched++; $display("FAIL abort_run1: got %h expected 605", {busy, tick, done, cnt});
    end
    next_cycle();
    set_in(0, 8'h00, 1, 1);
    @(negedge clk);
    compared++;
    if ({busy, tick, done, cnt} !== {1'b1, 1'b0, 1'b0, 8'd4}) begin
      mismatched++; $display("FAIL abort_no_tick: got %h expected 404", {busy, tick, done, cnt});
    end
    next_cycle();
    set_in(0, 8'h00, 1, 0);
    @(negedge clk);
    compared++;
    if ({busy, tick, done, cnt} !== {1'b0, 1'b0, 1'b1, 8'd0}) begin
      mismatched++; $display("FAIL abort_done: got %h expected 100", {busy, tick, done, cnt});
    end
    next_cycle();
  endtask

  task automatic test_boundaries();
    int ticks, lat;
    do_reset();
    run_burst(8'd0, GOOD, ticks, lat);
    compared++;
    if (ticks !== 0 || lat !== 1) begin
      mismatched++; $display("FAIL bound_idle_len0: got ticks=%0d lat=%0d expected ticks=0 lat=1", ticks, lat);
    end
    run_burst(8'd3, 8'h03, ticks, lat);
    set_in(0, 8'h00, 1, 0);
    next_cycle();
    run_burst(8'hFF, 8'h03, ticks, lat);
    compared++;
    if (ticks !== 0 || lat !== 1) begin
      mismatched++; $display("FAIL bound_di0_ff: got ticks=%0d lat=%0d expected ticks=0 lat=1", ticks, lat);
    end
    run_burst(8'hFC, 8'h03, ticks, lat);
    compared++;
    if (ticks !== 0 || lat !== 1) begin
      mismatched++; $display("FAIL bound_di3_fc: got ticks=%0d lat=%0d expected ticks=0 lat=1", ticks, lat);
    end
  endtask

  task automatic test_reset_mid_run();
    int ticks, lat;
    do_reset();
    keyinput = GOOD;
    set_in(1, 8'd4, 1, 0);
    next_cycle();
    set_in(0, 8'h00, 0, 0);
    @(negedge clk);
    compared++;
    if ({busy, cnt} !== {1'b1, 8'd4}) begin
      mismatched++; $display("FAIL midrun_pre: got %h expected 104", {busy, cnt});
    end
    en = 1'b1;
    #1; rst = 1'b1; #1;
    compared++;
    if ({busy, tick, done, cnt} !== 11'b0) begin
      mismatched++; $display("FAIL midrun_reset: got %h expected 000", {busy, tick, done, cnt});
    end
    @(posedge clk); #1; rst = 1'b0;
    set_in(0, 8'h00, 1, 0);
    next_cycle();
    run_burst(8'd2, 8'h03, ticks, lat);
    compared++;
    if (ticks !== 2 || lat !== 3) begin
      mismatched++; $display("FAIL midrun_first: got ticks=%0d lat=%0d expected ticks=2 lat=3", ticks, lat);
    end
    run_burst(8'd2, GOOD, ticks, lat);
    compared++;
    if (ticks !== 6 || lat !== 7) begin
      mismatched++; $display("FAIL midrun_locked: got ticks=%0d lat=%0d expected ticks=6 lat=7", ticks, lat);
    end
    run_burst(8'd2, GOOD, ticks, lat);
    compared++;
    if (ticks !== 2 || lat !== 3) begin
      mismatched++; $display("FAIL midrun_recovered: got ticks=%0d lat=%0d expected ticks=2 lat=3", ticks, lat);
    end
  endtask

  task automatic test_random();
    logic [10:0] exp_v;
    for (int i = 0; i < 1500; i++) begin
      rst      = ($urandom_range(0, 99) == 0);
      start    = ($urandom_range(0, 9) < 3);
      len      = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
      en       = ($urandom_range(0, 3) != 0);
      abort    = ($urandom_range(0, 9) == 0);
      keyinput = ($urandom_range(0, 1) == 0) ? GOOD : 8'($urandom);
      @(negedge clk);
      exp_v = {m_mode == 1, (m_mode == 1) && en && !abort, m_mode == 2, 8'(m_cnt)};
      compared++;
      if ({busy, tick, done, cnt} !== exp_v) begin
        mismatched++;
        $display("FAIL random_cycle%0d: got %h expected %h", i, {busy, tick, done, cnt}, exp_v);
      end
      next_cycle();
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_correct_key();
    test_wrong_key();
    test_en_gating();
    test_abort();
    test_boundaries();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/keyed_dupe_burst_fsm.md
# keyed_dupe_burst_fsm

Key-locked burst controller: on `start` it runs a programmable number of `tick` cycles, then signals `done`. Locking uses state duplication generalised to N_DUPE duplicate idle states and a KEY_W-bit key. With a wrong key, the machine falls into duplicate idle states that look identical at the outputs but corrupt the next burst length. It sits in the locked-FSM benchmark set as the parametrised successor of the single-bit, single-duplicate locked controllers.

## Interface
- KEY_W, 8, key width
- CORRECT_KEY, 8'hA5, unlocking key value
- N_DUPE, 4, number of duplicate idle states DI[0..N_DUPE-1]; power of 2, ≥2; IDX_W = log2(N_DUPE) ≤ KEY_W
- LEN_W, 8, burst-length and counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  burst request; sampled in IDLE/DI only
- len  in  LEN_W  requested tick count, sampled with start
- en  in  1  advance enable while running
- abort  in  1  terminate running burst
- keyinput  in  KEY_W  locking key
- busy  out  1  high in RUN
- tick  out  1  RUN && en && !abort (combinational)
- done  out  1  high in DONE
- cnt  out  LEN_W  remaining-count register

## Operation
- States: IDLE, RUN, DONE, DI[0..N_DUPE-1]. The encoding is implementer's choice; unreachable encodings go to IDLE with cnt=0.
- Reset (async, any state): state=IDLE, cnt=0; busy=tick=done=0.
- IDLE:
  - start=1, len≠0 → RUN, cnt=len.
  - start=1, len=0 → DONE, cnt=0.
  - Otherwise stay.
- DI[i]:
  - start=1 → effective length E=(len+i+1) mod 2^LEN_W. E≠0 → RUN, cnt=E. E=0 → DONE, cnt=0.
  - No start → DI[(i+1) mod N_DUPE]. The walk makes the corruption offset depend on idle time.
  - Outputs are identical to IDLE: all zero, cnt unchanged.
- RUN:
  - abort=1 (priority over en) → DONE, cnt=0, no tick.
  - en=1 and cnt=1 → tick, DONE, cnt=0.
  - en=1 and cnt>1 → tick, cnt−1, stay.
  - en=0 → hold.
  - start is ignored.
- DONE (always exactly one cycle): keyinput==CORRECT_KEY → IDLE; else → DI[keyinput[IDX_W-1:0]]. Key is sampled only at this edge; start and len are ignored.
- Recovery: a correct key at any later DONE returns to IDLE. Reset always returns to IDLE, so the first burst after reset is always correct regardless of key.
- Counter arithmetic is LEN_W-bit unsigned with wrap; cnt never underflows.

## Timing
- Start accepted at edge t: RUN visible from cycle t+1.
- With en held high and len=L≥1: tick in cycles t+1..t+L, DONE in cycle t+L+1, IDLE/DI in cycle t+L+2.
- Start-to-done latency is L+1 cycles; each en=0 cycle adds one.
- len=0: DONE at t+1, no tick.
- Back-to-back: start is accepted in the cycle after DONE (IDLE/DI), never in DONE itself.
- Abort at cycle k of RUN: no tick at k, DONE at k+1.
- busy, done and cnt are registered. tick is the only combinational output.

## Test plan
- Correct key (8'hA5), defaults. Reset, start len=3, en=1 held → tick cycles 1–3, done cycle 4, cnt 3,2,1,0. Repeat → identical 3 ticks.
- Wrong key 8'h03. First burst len=3 → 3 ticks (post-reset). DONE → DI[3]; start len=3 in the very next cycle → E=7, 7 ticks, then done. Hold start low 1 cycle instead (DI[0]) → E=4, 4 ticks.
- en gating: len=2, en pattern 1,0,1 → ticks only on en=1 cycles, cnt 2→1→1→0, done in the cycle after the second tick.
- abort asserted in the 2nd RUN cycle of a len=5 burst → 1 tick total, done the next cycle, cnt=0. abort together with en=1 → no tick.
- Boundaries:
  - IDLE len=0 → done at t+1, no tick.
  - DI[0] with len=8'hFF → E=0, done at t+1, no tick.
  - DI[3] with len=8'hFC → E=0, done.
- Reset mid-RUN (cnt=4) → busy/tick/done/cnt all 0 immediately. Next burst len=2 with key 8'h03 → exactly 2 ticks. Following DONE with key 8'hA5 → IDLE; next len=2 → 2 ticks.
